// File: rtl/vga_pixel_gen_pkg.sv
// Shared constants and types for the VGA pixel generator.
// Display geometry, ROM latency, sprite size and transparency key live here
// so the top level, the sprite hit calculator and the bench agree on them.
package vga_pixel_gen_pkg;

    // Display-area coordinate widths (640 columns, 480 rows).
    localparam int H_DISP_LEN     = 10;
    localparam int V_DISP_LEN     = 9;

    // Request-to-pixel latency: one address register plus one ROM cycle.
    localparam int ROM_READ_DELAY = 2;

    // Background is a 320x240 image shown pixel-doubled.
    localparam int BG_ADDR_LEN    = 17;
    localparam int BG_WIDTH       = 320;

    // Square sprite, 32x32 pixels, one ROM word per pixel.
    localparam int SPR_SIZE       = 32;
    localparam int SPR_ADDR_LEN   = 10;

    localparam int RGB_LEN        = 12;
    localparam int FRAME_CNT_LEN  = 8;

    // Sprite colour treated as "see-through" to the background.
    localparam logic [RGB_LEN-1:0] TRANSP_KEY = 12'hF0F;

    typedef logic [H_DISP_LEN-1:0] x_addr_t;
    typedef logic [V_DISP_LEN-1:0] y_addr_t;

    // Per-pixel tag carried alongside the ROM read so it lines up with the data.
    typedef struct packed {
        logic valid;
        logic hit;
    } pix_tag_t;

    // Background ROM address for a display pixel: halve both coordinates to
    // map the 640x480 screen onto the 320x240 source image.
    function automatic logic [BG_ADDR_LEN-1:0] calc_bg_addr(input x_addr_t x, input y_addr_t y);
        logic [BG_ADDR_LEN-1:0] row;
        logic [BG_ADDR_LEN-1:0] col;
        row = BG_ADDR_LEN'(y >> 1);
        col = BG_ADDR_LEN'(x >> 1);
        return row * BG_ADDR_LEN'(BG_WIDTH) + col;
    endfunction

endpackage

// File: rtl/vga_pixel_gen_if.sv
// Pixel-request bus from the VGA timing driver to the pixel generator.
//
// Handshake: req_i is a valid-only strobe. The generator has no ready signal
// and accepts one request per clock whenever req_i=1; req_x_addr_i and
// req_y_addr_i are only meaningful in that cycle. disp_i and v_sync_i are
// free-running timing levels, not part of the request.
interface vga_pixel_gen_if;
    import vga_pixel_gen_pkg::*;

    logic    req_i;
    x_addr_t req_x_addr_i;
    y_addr_t req_y_addr_i;
    logic    disp_i;
    logic    v_sync_i;

    // Timing driver side.
    modport master (
        output req_i,
        output req_x_addr_i,
        output req_y_addr_i,
        output disp_i,
        output v_sync_i
    );

    // Pixel generator side.
    modport slave (
        input req_i,
        input req_x_addr_i,
        input req_y_addr_i,
        input disp_i,
        input v_sync_i
    );

endinterface

// File: rtl/vga_pixel_gen_spr_hit_calc.sv
// Sprite hit test and sprite ROM address for one requested pixel.
// Purely combinational; the caller registers the results. Comparisons are
// done one bit wider than the coordinates so a sprite near the right or
// bottom edge never wraps around to column/row 0.
module vga_pixel_gen_spr_hit_calc
    import vga_pixel_gen_pkg::*;
(
    input  x_addr_t                 i_x,
    input  y_addr_t                 i_y,
    input  x_addr_t                 i_spr_x,
    input  y_addr_t                 i_spr_y,
    output logic                    o_hit,
    output logic [SPR_ADDR_LEN-1:0] o_addr
);

    logic [H_DISP_LEN:0]   w_x_ext;
    logic [H_DISP_LEN:0]   w_sx_lo;
    logic [H_DISP_LEN:0]   w_sx_hi;
    logic [V_DISP_LEN:0]   w_y_ext;
    logic [V_DISP_LEN:0]   w_sy_lo;
    logic [V_DISP_LEN:0]   w_sy_hi;
    logic                  w_hit_x;
    logic                  w_hit_y;
    x_addr_t               w_dx;
    y_addr_t               w_dy;

    assign w_x_ext = {1'b0, i_x};
    assign w_sx_lo = {1'b0, i_spr_x};
    assign w_sx_hi = w_sx_lo + (H_DISP_LEN+1)'(SPR_SIZE);
    assign w_y_ext = {1'b0, i_y};
    assign w_sy_lo = {1'b0, i_spr_y};
    assign w_sy_hi = w_sy_lo + (V_DISP_LEN+1)'(SPR_SIZE);

    assign w_dx = i_x - i_spr_x;
    assign w_dy = i_y - i_spr_y;

    // Window test in both axes, then row-major offset inside the sprite.
    always_comb begin
        w_hit_x = (w_x_ext >= w_sx_lo) && (w_x_ext < w_sx_hi);
        w_hit_y = (w_y_ext >= w_sy_lo) && (w_y_ext < w_sy_hi);
        o_hit   = w_hit_x && w_hit_y;
        o_addr  = '0;
        if (o_hit) begin
            o_addr = SPR_ADDR_LEN'(w_dy) * SPR_ADDR_LEN'(SPR_SIZE) + SPR_ADDR_LEN'(w_dx);
        end
    end

endmodule

// File: rtl/vga_pixel_gen.sv
// VGA pixel generator: turns pixel requests into ROM addresses and, two
// clocks later, an RGB444 colour built from the background image with an
// optional 32x32 sprite overlaid on top.
//
// Build option: define SPRITE_OVERLAY_EN to compile in the sprite path
// (hit test, sprite ROM address, shadow position registers, colour key).
// Without it the sprite inputs are ignored, spr_rom_addr_o is 0 and the
// output is background only, with the same two-cycle latency.
//
// Sprite position is sampled once per frame (on the rising edge of the
// registered v_sync) so a mid-frame move never tears the image.
module vga_pixel_gen
    import vga_pixel_gen_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    vga_pixel_gen_if.slave           pix_if,
    input  x_addr_t                  spr_x_i,
    input  y_addr_t                  spr_y_i,
    output logic [BG_ADDR_LEN-1:0]   bg_rom_addr_o,
    input  logic [RGB_LEN-1:0]       bg_rom_data_i,
    output logic [SPR_ADDR_LEN-1:0]  spr_rom_addr_o,
    input  logic [RGB_LEN-1:0]       spr_rom_data_i,
    output logic [RGB_LEN-1:0]       rgb_o,
    output logic                     frame_tick_o,
    output logic [FRAME_CNT_LEN-1:0] frame_cnt_o
);

    logic [BG_ADDR_LEN-1:0]            r_bg_addr;
    pix_tag_t [ROM_READ_DELAY-1:0]     r_tag_pipe;
    pix_tag_t                          w_tag_in;
    logic                              w_hit;
    logic                              r_vsync_q;
    logic                              w_frame_start;
    logic                              r_frame_tick;
    logic [FRAME_CNT_LEN-1:0]          r_frame_cnt;
    logic [RGB_LEN-1:0]                w_rgb;

    // A frame begins when v_sync leaves its active-low pulse.
    assign w_frame_start = pix_if.v_sync_i & ~r_vsync_q;

`ifdef SPRITE_OVERLAY_EN
    x_addr_t                   r_spr_x_shadow;
    y_addr_t                   r_spr_y_shadow;
    logic [SPR_ADDR_LEN-1:0]   r_spr_addr;
    logic [SPR_ADDR_LEN-1:0]   w_spr_addr;

    // Latch the sprite position at frame start; it stays fixed for the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_spr_x_shadow <= '0;
            r_spr_y_shadow <= '0;
        end else if (w_frame_start) begin
            r_spr_x_shadow <= spr_x_i;
            r_spr_y_shadow <= spr_y_i;
        end
    end

    vga_pixel_gen_spr_hit_calc u_spr_hit_calc (
        .i_x     (pix_if.req_x_addr_i),
        .i_y     (pix_if.req_y_addr_i),
        .i_spr_x (r_spr_x_shadow),
        .i_spr_y (r_spr_y_shadow),
        .o_hit   (w_hit),
        .o_addr  (w_spr_addr)
    );

    // Sprite ROM address register; parked at 0 when there is no hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_spr_addr <= '0;
        end else if (pix_if.req_i && w_hit) begin
            r_spr_addr <= w_spr_addr;
        end else begin
            r_spr_addr <= '0;
        end
    end

    assign spr_rom_addr_o = r_spr_addr;
`else
    logic w_unused_spr;

    assign w_hit          = 1'b0;
    assign spr_rom_addr_o = '0;
    assign w_unused_spr   = ^{spr_x_i, spr_y_i, spr_rom_data_i, r_tag_pipe[ROM_READ_DELAY-1].hit};
`endif

    // Background ROM address register; parked at 0 when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bg_addr <= '0;
        end else if (pix_if.req_i) begin
            r_bg_addr <= calc_bg_addr(pix_if.req_x_addr_i, pix_if.req_y_addr_i);
        end else begin
            r_bg_addr <= '0;
        end
    end

    assign bg_rom_addr_o = r_bg_addr;

    // Tag for the pixel entering the pipeline this cycle.
    always_comb begin
        w_tag_in       = '0;
        w_tag_in.valid = pix_if.req_i;
        w_tag_in.hit   = pix_if.req_i & w_hit;
    end

    // Valid/hit shift pipeline, aligned with the ROM data at its last stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_pipe <= '0;
        end else begin
            r_tag_pipe <= {r_tag_pipe[ROM_READ_DELAY-2:0], w_tag_in};
        end
    end

    // v_sync history, frame-start pulse and wrapping frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync_q    <= 1'b1;
            r_frame_tick <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_vsync_q    <= pix_if.v_sync_i;
            r_frame_tick <= w_frame_start;
            if (w_frame_start) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign frame_tick_o = r_frame_tick;
    assign frame_cnt_o  = r_frame_cnt;

    // Output colour: blank outside the visible area, for empty slots and
    // while reset is held; sprite wins over background unless colour-keyed.
    always_comb begin
        w_rgb = '0;
        if (!rst && pix_if.disp_i && r_tag_pipe[ROM_READ_DELAY-1].valid) begin
            w_rgb = bg_rom_data_i;
`ifdef SPRITE_OVERLAY_EN
            if (r_tag_pipe[ROM_READ_DELAY-1].hit && (spr_rom_data_i != TRANSP_KEY)) begin
                w_rgb = spr_rom_data_i;
            end
`endif
        end
    end

    assign rgb_o = w_rgb;

endmodule

// File: doc/vga_pixel_gen.md
VGA_PIXEL_GEN -- requirements
Module: vga_pixel_gen

Interface
REQ-001 clk  in  1  pixel clock; all state changes on its rising edge.
REQ-002 rst  in  1  reset; synchronous, active-high.
REQ-003 req_i  in  1  pixel-request valid from the VGA timing driver.
REQ-004 req_x_addr_i  in  H_DISP_LEN  requested display-area column, already advanced by ROM_READ_DELAY.
REQ-005 req_y_addr_i  in  V_DISP_LEN  requested display-area row.
REQ-006 disp_i  in  1  current pixel lies in the visible area.
REQ-007 v_sync_i  in  1  vertical sync, active-low.
REQ-008 spr_x_i / spr_y_i  in  H_DISP_LEN / V_DISP_LEN  sprite top-left position from game logic.
REQ-009 bg_rom_addr_o  out  BG_ADDR_LEN (17)  background ROM address.
REQ-010 bg_rom_data_i  in  12  background RGB444; synchronous ROM with 1-cycle read latency.
REQ-011 spr_rom_addr_o  out  10  sprite ROM address.
REQ-012 spr_rom_data_i  in  12  sprite RGB444; synchronous ROM with 1-cycle read latency.
REQ-013 rgb_o  out  12  pixel colour to the DAC.
REQ-014 frame_tick_o  out  1  one-cycle pulse at each frame start.
REQ-015 frame_cnt_o  out  8  frame counter.

Function
REQ-016 Background address SHALL be (y>>1)*320 + (x>>1) (320x240 source doubled to 640x480); it is registered one cycle after req_i and is 0 when req_i=0.
REQ-017 Total latency from req_i to rgb_o SHALL be ROM_READ_DELAY (2) cycles: 1 address register plus 1 ROM cycle.
REQ-018 A valid/hit shift pipeline of depth ROM_READ_DELAY SHALL carry req_i and the sprite-hit flag, aligned with the ROM data.
REQ-019 Sprite hit: spr_x <= x < spr_x+32 and spr_y <= y < spr_y+32, evaluated at width+1 bits so no wrap at right or bottom edges.
REQ-020 On hit, spr_rom_addr_o SHALL be registered as (y-spr_y)*32 + (x-spr_x); otherwise it SHALL be 0.
REQ-021 rgb_o SHALL be 0 when disp_i=0 or the pipelined valid bit is 0.
REQ-022 rgb_o SHALL be spr_rom_data_i when the pipelined hit bit is 1 and the data is not TRANSP_KEY (12'hF0F); otherwise it SHALL be bg_rom_data_i.
REQ-023 Frame start is a 0->1 transition of registered v_sync_i.
REQ-024 At frame start, spr_x_i and spr_y_i SHALL be latched into shadow registers used for the whole frame, frame_tick_o SHALL pulse for 1 cycle, and frame_cnt_o SHALL increment, wrapping 255->0.
REQ-025 A position change mid-frame SHALL take effect at the next frame start only (no tearing).

Reset
REQ-026 While rst=1, all of the following SHALL be held at the given value: rgb_o 0, both ROM addresses 0, pipeline cleared, shadow positions 0, frame_cnt_o 0, frame_tick_o 0, v_sync history register 1.
REQ-027 Reset asserted mid-line SHALL blank the output within 1 cycle.
REQ-028 After reset is released, the first pixel SHALL be emitted after a full pipeline refill, with no stale data.

Configuration
REQ-029 Macro SPRITE_OVERLAY_EN: when defined, the sprite path (REQ-019 to REQ-022 sprite branch, shadow registers) SHALL be compiled in.
REQ-030 When SPRITE_OVERLAY_EN is undefined, spr_rom_addr_o SHALL be tied to 0, the sprite inputs SHALL be ignored, and rgb_o SHALL be the background only; the latency SHALL be unchanged.

Structure
REQ-031 H_DISP_LEN, V_DISP_LEN, ROM_READ_DELAY, BG_ADDR_LEN, SPR_SIZE (32) and TRANSP_KEY SHALL reside in the shared define header.
REQ-032 One sub-module, spr_hit_calc (hit compare plus sprite address), is natural; everything else SHALL be in vga_pixel_gen.

Verification
REQ-033 req at x=0,y=0 -> bg_rom_addr_o=0 after 1 cycle; rgb_o=bg data after 2 cycles.
REQ-034 x=639,y=479 -> bg_rom_addr_o=239*320+319=76799.
REQ-035 Sprite at (100,50), pixel (131,81), sprite data 12'h0F0 -> rgb_o=12'h0F0; at (132,81) -> background.
REQ-036 Sprite data 12'hF0F inside sprite -> rgb_o = background colour; sprite at x=620, pixel x=639 is a hit with no wrap at x=0.
REQ-037 spr_x_i changed mid-frame -> hits use the old value until the v_sync_i 0->1 edge; frame_tick_o pulses once; frame_cnt_o 255->0.
REQ-038 rst pulsed mid-line with disp_i=1 -> rgb_o=0 the next cycle; the first valid pixel appears 2 cycles after the next req_i.
